// File: rtl/rr_arb_hier_hs.sv
// Two-level round-robin arbiter: parent picks a group, child picks a lane in it.
// Grant is registered and held until ack; a dropped request cancels the grant.
module rr_arb_hier_hs #(
   parameter  int N_GROUPS   = 4,
   parameter  int GROUP_SIZE = 8,
   parameter  int BURST_LEN  = 1,
   localparam int REQ_NB     = N_GROUPS * GROUP_SIZE,
   localparam int IDX_W      = (REQ_NB > 1) ? $clog2(REQ_NB) : 1
) (
   input  logic              clk_i,
   input  logic              srst,
   input  logic              en,
   input  logic [REQ_NB-1:0] req,
   input  logic              ack,
   output logic [REQ_NB-1:0] grant,
   output logic              grant_valid,
   output logic [IDX_W-1:0]  grant_idx,
   output logic              cancel
);
   localparam int GP_W = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1;
   localparam int LP_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;
   localparam int BC_W = $clog2(BURST_LEN + 1);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t            state_q;
   logic [REQ_NB-1:0] grant_q;
   logic              grant_valid_q;
   logic [IDX_W-1:0]  grant_idx_q;
   logic              cancel_q;
   logic [GP_W-1:0]   parent_ptr_q;
   logic [LP_W-1:0]   child_ptr_q [N_GROUPS];
   logic [BC_W-1:0]   burst_cnt_q;
   logic [GP_W-1:0]   held_g_q;
   logic [LP_W-1:0]   held_j_q;

   logic [N_GROUPS-1:0]   group_any;
   logic [GROUP_SIZE-1:0] win_req;
   logic [GROUP_SIZE-1:0] held_req;
   logic [GP_W-1:0]       win_g;
   logic [LP_W-1:0]       win_j;
   logic [IDX_W-1:0]      win_idx;
   logic [REQ_NB-1:0]     win_onehot;
   logic [GP_W-1:0]       next_g;
   logic [LP_W-1:0]       next_j;
   logic                  held_live;
   logic                  held_others;
   logic                  burst_done;

   function automatic int wrap_add(input int a, input int b, input int m);
      int s;
      s = a + b;
      return (s >= m) ? s - m : s;
   endfunction

   always_comb begin
      logic [GP_W-1:0] cand_g;
      logic [LP_W-1:0] cand_j;
      group_any = '0;
      win_g     = '0;
      win_j     = '0;
      cand_g    = '0;
      cand_j    = '0;
      for (int g = 0; g < N_GROUPS; g++)
         group_any[g] = |req[g*GROUP_SIZE +: GROUP_SIZE];
      // Scanning from the farthest offset down lets the nearest candidate overwrite the rest.
      for (int k = N_GROUPS - 1; k >= 0; k--) begin
         cand_g = GP_W'(wrap_add(int'(parent_ptr_q), k, N_GROUPS));
         if (group_any[cand_g]) win_g = cand_g;
      end
      win_req = GROUP_SIZE'(req >> (int'(win_g) * GROUP_SIZE));
      for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
         cand_j = LP_W'(wrap_add(int'(child_ptr_q[win_g]), k, GROUP_SIZE));
         if (win_req[cand_j]) win_j = cand_j;
      end
      win_idx             = IDX_W'(int'(win_g) * GROUP_SIZE + int'(win_j));
      win_onehot          = '0;
      win_onehot[win_idx] = 1'b1;
   end

   always_comb begin
      held_req    = GROUP_SIZE'(req >> (int'(held_g_q) * GROUP_SIZE));
      held_live   = req[grant_idx_q];
      held_others = |(held_req & ~(GROUP_SIZE'(1) << held_j_q));
      burst_done  = ((int'(burst_cnt_q) + 1) == BURST_LEN) || !held_others;
      next_g      = GP_W'(wrap_add(int'(held_g_q), 1, N_GROUPS));
      next_j      = LP_W'(wrap_add(int'(held_j_q), 1, GROUP_SIZE));
   end

   always_ff @(posedge clk_i) begin
      if (srst) begin
         state_q       <= IDLE;
         grant_q       <= '0;
         grant_valid_q <= 1'b0;
         grant_idx_q   <= '0;
         cancel_q      <= 1'b0;
         parent_ptr_q  <= '0;
         burst_cnt_q   <= '0;
         held_g_q      <= '0;
         held_j_q      <= '0;
         for (int g = 0; g < N_GROUPS; g++)
            child_ptr_q[g] <= '0;
      end else begin
         cancel_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (en && |req) begin
                  grant_q       <= win_onehot;
                  grant_idx_q   <= win_idx;
                  grant_valid_q <= 1'b1;
                  held_g_q      <= win_g;
                  held_j_q      <= win_j;
                  state_q       <= GRANT;
               end
            end
            GRANT: begin
               if (!held_live) begin
                  cancel_q      <= 1'b1;
                  grant_q       <= '0;
                  grant_idx_q   <= '0;
                  grant_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end else if (ack) begin
                  child_ptr_q[held_g_q] <= next_j;
                  // Parent stays on this group while its burst continues.
                  if (burst_done) begin
                     parent_ptr_q <= next_g;
                     burst_cnt_q  <= '0;
                  end else begin
                     parent_ptr_q <= held_g_q;
                     burst_cnt_q  <= burst_cnt_q + 1'b1;
                  end
                  grant_q       <= '0;
                  grant_idx_q   <= '0;
                  grant_valid_q <= 1'b0;
                  state_q       <= IDLE;
               end
            end
         endcase
      end
   end

   assign grant       = grant_q;
   assign grant_valid = grant_valid_q;
   assign grant_idx   = grant_idx_q;
   assign cancel      = cancel_q;

endmodule

// File: tb/tb_rr_arb_hier_hs.sv
// Directed and randomized checks of rr_arb_hier_hs against a lane-priority reference model.
module tb_rr_arb_hier_hs;
   localparam int NG = 4;
   localparam int GS = 8;
   localparam logic [31:0] GMASK = 32'h0000_00FF;

   logic        clk = 1'b0;
   logic        srst, en, ack;
   logic [31:0] req;
   logic [31:0] grant;
   logic        grant_valid, cancel;
   logic [4:0]  grant_idx;

   logic        b_srst, b_en, b_ack;
   logic [31:0] b_req;
   logic [31:0] b_grant;
   logic        b_gv, b_cancel;
   logic [4:0]  b_idx;

   int n_asrt = 0;
   int n_fail = 0;

   int m_pp, m_burst, m_idx;
   int m_cp [NG];
   bit m_held, m_cancel;

   logic [31:0] cover_q;

   always #5 clk = ~clk;

   rr_arb_hier_hs dut (
      .clk_i(clk), .srst(srst), .en(en), .req(req), .ack(ack),
      .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx), .cancel(cancel)
   );

   rr_arb_hier_hs #(.BURST_LEN(2)) dut_b (
      .clk_i(clk), .srst(b_srst), .en(b_en), .req(b_req), .ack(b_ack),
      .grant(b_grant), .grant_valid(b_gv), .grant_idx(b_idx), .cancel(b_cancel)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Priority order: groups cyclic from parent pointer, lanes cyclic from that group's pointer.
   function automatic int pick(input logic [31:0] r);
      for (int k = 0; k < NG; k++) begin
         int g;
         g = (m_pp + k) % NG;
         if (((r >> (g * GS)) & GMASK) != 0)
            for (int m = 0; m < GS; m++)
               if (r[g * GS + (m_cp[g] + m) % GS]) return g * GS + (m_cp[g] + m) % GS;
      end
      return 0;
   endfunction

   task automatic model_step();
      m_cancel = 1'b0;
      if (srst) begin
         m_pp = 0; m_burst = 0; m_idx = 0; m_held = 1'b0;
         for (int g = 0; g < NG; g++) m_cp[g] = 0;
      end else if (!m_held) begin
         if (en && req != 0) begin
            m_idx  = pick(req);
            m_held = 1'b1;
         end
      end else if (!req[m_idx]) begin
         m_held   = 1'b0;
         m_cancel = 1'b1;
      end else if (ack) begin
         int g, j;
         logic [31:0] others;
         g = m_idx / GS;
         j = m_idx % GS;
         others = (req >> (g * GS)) & GMASK;
         others[j] = 1'b0;
         m_cp[g] = (j + 1) % GS;
         m_burst++;
         if (m_burst == 1 || others == 0) begin
            m_pp = (g + 1) % NG;
            m_burst = 0;
         end else begin
            m_pp = g;
         end
         m_held = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".grant"}, grant, m_held ? (32'd1 << m_idx) : 32'd0);
      chk({tag, ".idx"}, {27'd0, grant_idx}, m_held ? m_idx : 0);
      chk({tag, ".valid"}, {31'd0, grant_valid}, {31'd0, m_held});
      chk({tag, ".cancel"}, {31'd0, cancel}, {31'd0, m_cancel});
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".grant"}, grant, 32'd0);
      chk({tag, ".idx"}, {27'd0, grant_idx}, 32'd0);
      chk({tag, ".valid"}, {31'd0, grant_valid}, 32'd0);
      chk({tag, ".cancel"}, {31'd0, cancel}, 32'd0);
   endtask

   initial begin
      srst = 1'b1; en = 1'b0; ack = 1'b0; req = '0;
      b_srst = 1'b1; b_en = 1'b0; b_ack = 1'b0; b_req = '0;

      // reset / idle
      tick(); tick();
      chk_idle("reset");
      srst = 1'b0; en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("idle");
      end

      // basic handshake
      req = 32'h1;
      tick(); chk("hs.t1.grant", grant, 32'h1); chk("hs.t1.idx", {27'd0, grant_idx}, 32'd0);
      tick(); chk("hs.t2.grant", grant, 32'h1);
      tick(); chk("hs.t3.grant", grant, 32'h1); chk("hs.t3.valid", {31'd0, grant_valid}, 32'd1);
      ack = 1'b1;
      tick(); chk("hs.t4.grant", grant, 32'h0); chk("hs.t4.valid", {31'd0, grant_valid}, 32'd0);
      ack = 1'b0;
      tick(); chk("hs.t5.grant", grant, 32'h1); chk("hs.t5.idx", {27'd0, grant_idx}, 32'd0);
      ack = 1'b1;
      tick(); chk("hs.t6.grant", grant, 32'h0);
      ack = 1'b0; req = '0;
      tick();

      // full rotation
      srst = 1'b1; tick(); srst = 1'b0;
      req = 32'hFFFF_FFFF; ack = 1'b1; cover_q = '0;
      for (int k = 0; k < 32; k++) begin
         tick();
         chk($sformatf("rot.idx%0d", k), {27'd0, grant_idx}, (k % 4) * 8 + k / 4);
         cover_q |= grant;
         tick();
         chk($sformatf("rot.gap%0d", k), {31'd0, grant_valid}, 32'd0);
      end
      chk("rot.cover", cover_q, 32'hFFFF_FFFF);
      req = '0; ack = 1'b0;
      tick();

      // burst fairness on the BURST_LEN=2 instance
      b_srst = 1'b0; b_en = 1'b1; b_ack = 1'b1; b_req = 32'hFFFF_FFFF;
      for (int k = 0; k < 16; k++) begin
         tick();
         chk($sformatf("burst.idx%0d", k), {27'd0, b_idx},
             ((k / 2) % 4) * 8 + 2 * ((k / 2) / 4) + (k % 2));
         tick();
      end
      b_srst = 1'b1;

      // cancel
      srst = 1'b1; tick(); srst = 1'b0;
      req = 32'h0000_0100;
      tick(); chk("cxl.idx", {27'd0, grant_idx}, 32'd8); chk("cxl.grant", grant, 32'h100);
      req = '0;
      tick(); chk("cxl.pulse", {31'd0, cancel}, 32'd1); chk("cxl.grant0", grant, 32'h0);
      tick(); chk("cxl.pulse_end", {31'd0, cancel}, 32'd0);
      req = 32'h0000_0100;
      tick(); chk("cxl.regrant", {27'd0, grant_idx}, 32'd8);
      req = '0; ack = 1'b1;
      tick(); chk("cxl.ackdrop", {31'd0, cancel}, 32'd1);
      ack = 1'b0;
      tick();

      // mid-grant disruption
      srst = 1'b1; tick(); srst = 1'b0;
      req = 32'hFFFF_FFFF; en = 1'b1;
      tick(); chk("mid.idx0", {27'd0, grant_idx}, 32'd0);
      en = 1'b0;
      tick(); chk("mid.hold", grant, 32'h1);
      ack = 1'b1;
      tick(); chk("mid.ack", grant, 32'h0); chk("mid.nocxl", {31'd0, cancel}, 32'd0);
      ack = 1'b0;
      tick(); chk("mid.en0", {31'd0, grant_valid}, 32'd0);
      en = 1'b1;
      tick(); chk("mid.next", {27'd0, grant_idx}, 32'd8);
      srst = 1'b1; ack = 1'b1;
      tick(); chk("mid.srst", grant, 32'h0); chk("mid.srst_cxl", {31'd0, cancel}, 32'd0);
      srst = 1'b0; ack = 1'b0;
      tick(); chk("mid.after", {27'd0, grant_idx}, 32'd0);

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         srst = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 3) != 0);
         ack  = $urandom_range(0, 1) != 0;
         case ($urandom_range(0, 3))
            0: req = $urandom;
            1: req = $urandom & $urandom & $urandom;
            2: req = 32'd1 << $urandom_range(0, 31);
            default: req = req ^ (32'd1 << $urandom_range(0, 31));
         endcase
         tick();
         chk_model($sformatf("rnd%0d", i));
         chk($sformatf("rnd%0d.onehot", i), {31'd0, $onehot0(grant)}, 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/rr_arb_hier_hs.md
Name: rr_arb_hier_hs

Overview:
- Parametrised two-level round-robin arbiter with a registered one-hot grant and a grant/ack handshake.
- Arbitrates N_GROUPS x GROUP_SIZE requesters, for example lanes contending for a shared Forney/error-value datapath in the RS(544,522) decoder.
- The parent level selects a group and the child level selects a lane within it.
- Adds over the earlier combinational arbiter:
  - a sticky grant held until acknowledged,
  - per-group burst fairness (BURST_LEN consecutive grants before the parent pointer advances),
  - a binary grant index,
  - cancellation when the granted request drops.

Parameters:
N_GROUPS, 4, number of groups (>=1)
GROUP_SIZE, 8, requesters per group (>=1)
BURST_LEN, 1, max consecutive acked grants to one group before the parent pointer moves (>=1)
REQ_NB, N_GROUPS*GROUP_SIZE, derived localparam, total requesters
IDX_W, $clog2(REQ_NB) (min 1), derived localparam, width of grant_idx

Ports:
clk_i  in  1  clock, all logic on rising edge
srst  in  1  synchronous reset, active-high
en  in  1  allows a new arbitration; does not affect a held grant
req  in  REQ_NB  request vector; lane l = g*GROUP_SIZE + j
ack  in  1  consumer accepts the current grant
grant  out  REQ_NB  registered one-hot grant, all-zero when idle
grant_valid  out  1  high while grant is non-zero
grant_idx  out  IDX_W  binary index of the granted lane, 0 when idle
cancel  out  1  one-cycle pulse: the held grant was withdrawn because its req dropped

Behaviour:
- Reset values: srst=1 forces, at the next edge:
  - state=IDLE, grant=0, grant_valid=0, grant_idx=0, cancel=0;
  - parent pointer=0, all child pointers=0, burst counter=0.
  - srst overrides everything, including mid-grant; no pointer updates occur that cycle.
- Pointers:
  - parent_ptr is a group index.
  - child_ptr[g] is a lane index within group g.
  - Each is the highest-priority candidate; search is cyclic upward from the pointer, with wrap-around modulo N_GROUPS or GROUP_SIZE.
- Arbitration (combinational, from current pointers):
  - group_any[g] = OR of that group's req bits.
  - win_g = first g with group_any, cyclic from parent_ptr.
  - win_j = first set bit of group win_g, cyclic from child_ptr[win_g].
- State IDLE:
  - If en && |req: register grant = onehot(win_g*GROUP_SIZE+win_j), grant_idx = that index, grant_valid=1; go to GRANT.
  - Latency: req high in cycle t gives grant visible in cycle t+1.
  - Otherwise stay in IDLE, outputs zero.
- State GRANT: grant, grant_idx and grant_valid are held stable, independent of en and of other req bits.
  - ack=1 and req[grant_idx]=1 (accept):
    - child_ptr[win_g] = (win_j+1) mod GROUP_SIZE.
    - burst_cnt+1; if it equals BURST_LEN, or no other req bit in win_g is set this cycle, then parent_ptr = (win_g+1) mod N_GROUPS and burst_cnt=0.
    - Otherwise parent_ptr = win_g.
    - Clear the grant and go to IDLE. Max throughput is one grant per 2 cycles.
  - req[grant_idx]=0 (with or without ack):
    - Cancel: cancel=1 for one cycle, grant cleared, go to IDLE.
    - No pointer or burst_cnt change. Ack on a dropped request is ignored.
  - ack=0 and req high: hold.
- burst_cnt width is $clog2(BURST_LEN+1). When BURST_LEN=1, the parent pointer advances on every accept.
- Parent pointer register:
  - Remembers the group whose burst is in progress.
  - On entry to IDLE, arbitration restarts from parent_ptr, so a group mid-burst wins first if it still requests.
- Degenerate sizes:
  - N_GROUPS=1: parent logic is constant and group 0 is always selected.
  - GROUP_SIZE=1: child pointers are constant 0.
- Invariants:
  - grant is always 0 or one-hot.
  - grant_valid == |grant.
  - grant only targets a lane whose req was high in the arbitration cycle.
  - Any continuously asserting lane is granted within REQ_NB*BURST_LEN accepts.

Test Plan:
- Reset/idle: srst=1 for 2 cycles, then req=0 -> grant=0, grant_valid=0, grant_idx=0, cancel=0 every cycle.
- Basic handshake (defaults): req=0x0000_0001 at t, ack at t+3 -> grant=0x1 and grant_idx=0 at t+1..t+3, grant=0 at t+4. A second request at t+4 is granted at t+5.
- Full rotation (defaults): req=0xFFFF_FFFF with ack every GRANT cycle -> grant_idx sequence 0,8,16,24,1,9,17,25,2,... All 32 lanes are covered in 32 grants.
- Burst fairness: BURST_LEN=2, req=0xFFFF_FFFF with immediate acks -> grant_idx 0,1,8,9,16,17,24,25,2,3,...
- Cancel: defaults; req=0x0000_0100 gives grant_idx=8. Drop req[8] with ack=0 -> cancel=1 for one cycle, grant=0. Re-assert req[8] -> grant_idx=8 again (pointers unchanged).
- Mid-grant disruption: en=0 while in GRANT -> grant is held and ack is still accepted. srst during GRANT with ack=1 -> grant=0 next cycle. Subsequent req=0xFFFF_FFFF yields grant_idx=0 (pointers reset).
